// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load extraction and register-file writeback
//
// One-entry buffer between the memory stage and the register file of the RV64I pipeline.
// A completed memory-stage instruction is captured on mem_valid && mem_ready and is
// committed combinationally in the following cycle unless wb_stall holds it.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mem_valid/mem_ready capture handshake from the memory stage
//   mem_pc, mem_alu_data, mem_load_raw, mem_funct3, mem_wb_sel, mem_reg_write, mem_rd
//                       fields of the completed instruction
//   wb_stall            blocks commit and holds the entry
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   sb_clear            scoreboard clear strobe for rf_waddr
//   wb_fault/wb_fault_pc     misaligned or illegal load at commit
//   instret             retired-instruction counter
//   fwd_valid/fwd_rd/fwd_data  execute-stage bypass (only with MEM_WB_FWD_EN defined)
//
// Optional feature macro: MEM_WB_FWD_EN
module mem_wb_stage #(
   parameter int XLEN       = 64,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [XLEN-1:0]       mem_pc,
   input  logic [XLEN-1:0]       mem_alu_data,
   input  logic [XLEN-1:0]       mem_load_raw,
   input  logic [2:0]            mem_funct3,
   input  logic [1:0]            mem_wb_sel,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  wb_stall,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  sb_clear,
   output logic                  wb_fault,
   output logic [XLEN-1:0]       wb_fault_pc,
   output logic [CNT_W-1:0]      instret
`ifdef MEM_WB_FWD_EN
   ,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_rd,
   output logic [XLEN-1:0]       fwd_data
`endif
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [XLEN-1:0]       pc_q;
   logic [XLEN-1:0]       alu_q;
   logic [XLEN-1:0]       raw_q;
   logic [2:0]            f3_q;
   logic [1:0]            sel_q;
   logic                  rw_q;
   logic [REG_ADDR_W-1:0] rd_q;

   logic            full;
   logic            commit;
   logic            capture;
   logic [2:0]      off;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_val;
   logic            load_fault;
   logic            fault;
   logic            writes_rd;
   logic [XLEN-1:0] wb_val;

   assign full = (state_q == ST_FULL);

   // Commit is suppressed while reset is high so an in-flight entry never writes.
   // mem_ready looks through a same-cycle commit so back-to-back entries flow.
   always_comb begin
      state_d   = state_q;
      commit    = full && !wb_stall && !reset;
      mem_ready = !full || commit;
      capture   = mem_valid && mem_ready;
      if (capture) begin
         state_d = ST_FULL;
      end else if (commit) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= '0;
         alu_q <= '0;
         raw_q <= '0;
         f3_q  <= '0;
         sel_q <= '0;
         rw_q  <= 1'b0;
         rd_q  <= '0;
      end else if (capture) begin
         pc_q  <= mem_pc;
         alu_q <= mem_alu_data;
         raw_q <= mem_load_raw;
         f3_q  <= mem_funct3;
         sel_q <= mem_wb_sel;
         rw_q  <= mem_reg_write;
         rd_q  <= mem_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instret <= '0;
      end else if (commit) begin
         instret <= instret + CNT_W'(1);
      end
   end

   // Move the addressed byte lane down to bit 0, then trim to the access size.
   assign off     = alu_q[2:0];
   assign shifted = raw_q >> {off, 3'b000};

   always_comb begin
      load_val = shifted;
      case (f3_q[1:0])
         2'b00: load_val = f3_q[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                   : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         2'b01: load_val = f3_q[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                   : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         2'b10: load_val = f3_q[2] ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                   : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         default: load_val = shifted;
      endcase
   end

   always_comb begin
      load_fault = 1'b0;
      case (f3_q)
         3'b001, 3'b101: load_fault = off[0];
         3'b010, 3'b110: load_fault = |off[1:0];
         3'b011:         load_fault = |off;
         3'b111:         load_fault = 1'b1;
         default:        load_fault = 1'b0;
      endcase
   end

   assign fault = full && (sel_q == 2'b01) && load_fault;

   always_comb begin
      wb_val = alu_q;
      case (sel_q)
         2'b01:   wb_val = load_val;
         2'b10:   wb_val = pc_q + XLEN'(4);
         default: wb_val = alu_q;
      endcase
   end

   assign writes_rd = rw_q && (rd_q != '0);

   // sb_clear ignores the fault so a faulting load still releases its scoreboard bit.
   assign rf_we       = commit && writes_rd && !fault;
   assign sb_clear    = commit && writes_rd;
   assign wb_fault    = commit && fault;
   assign rf_waddr    = full ? rd_q : '0;
   assign rf_wdata    = full ? wb_val : '0;
   assign wb_fault_pc = full ? pc_q : '0;

`ifdef MEM_WB_FWD_EN
   // Bypass is valid for the whole time the entry is held, stalled or not.
   assign fwd_valid = full && writes_rd && !fault;
   assign fwd_rd    = rd_q;
   assign fwd_data  = wb_val;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register and writeback logic directly downstream of the memory stage of the 64-bit RV64I pipeline.
- Captures each completed memory-stage result through a valid/ready handshake, then on commit:
  - extracts and sign/zero-extends load data from the raw 64-bit doubleword;
  - selects the writeback source;
  - drives the register-file write port, a scoreboard-clear strobe and a retire counter.
- One-entry buffer: throughput of one instruction per cycle, with back-pressure to the memory stage.

Parameters:
- XLEN, 64, datapath width; the only supported value is 64.
- REG_ADDR_W, 5, register index width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  memory stage presents a completed instruction (memory_done qualified).
- mem_ready  out  1  stage can accept this cycle.
- mem_pc  in  64  instruction PC.
- mem_alu_data  in  64  ALU result / effective address.
- mem_load_raw  in  64  raw aligned doubleword returned by the data cache.
- mem_funct3  in  3  load size/sign code.
- mem_wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- mem_reg_write  in  1  instruction writes rd.
- mem_rd  in  5  destination register.
- wb_stall  in  1  register-file port or hazard unit blocks commit.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  64  write data.
- sb_clear  out  1  scoreboard clear strobe for rf_waddr.
- wb_fault  out  1  misaligned or illegal load at commit.
- wb_fault_pc  out  64  PC of the faulting instruction.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (synchronous, active-high):
  - stage empty; instret=0.
  - rf_we, sb_clear and wb_fault are 0.
  - rf_waddr, rf_wdata and wb_fault_pc are 0.
  - mem_ready=1 in the first cycle after reset.
- An in-flight entry is discarded on reset: no write and no count.
- State: a full flag plus the captured fields. EMPTY and FULL are the only states.
- commit = full && !wb_stall.
- mem_ready = !full || commit. This is combinational so back-to-back flow occurs without bubbles.
- Capture: on a clock edge with mem_valid && mem_ready, all inputs are registered and full=1. Otherwise, if commit, full=0.
- A simultaneous commit and capture replaces the entry; full stays 1.
- Latency: an instruction captured at edge N is committed combinationally during cycle N+1 unless stalled. rf_* are valid in that cycle and the write lands at edge N+1.
- wb_stall holds the entry, all outputs stay stable, and rf_we=0 while stalled.
- Load extraction (when wb_sel=01):
  - offset = alu_data[2:0] selects the byte lane of mem_load_raw.
  - LB=000, LH=001, LW=010 and LD=011 sign-extend.
  - LBU=100, LHU=101 and LWU=110 zero-extend.
- Load fault conditions:
  - funct3 = 111;
  - LH/LHU with offset[0] set;
  - LW/LWU with offset[1:0] nonzero;
  - LD with offset nonzero.
- PC+4 source uses 64-bit wraparound: 0xFFFF_FFFF_FFFF_FFFC gives 0.
- rf_we = commit && reg_write && rd!=0 && !fault.
- sb_clear = commit && reg_write && rd!=0. It is asserted even on fault so the scoreboard never deadlocks.
- wb_fault = commit && wb_sel==01 && fault. wb_fault_pc is valid alongside it.
- instret increments by 1 on every commit, including rd=0 and faulting entries. It wraps at 2^CNT_W.
- rf_waddr and rf_wdata always reflect the held entry; they are 0 when empty.

Optional Feature:
- Macro MEM_WB_FWD_EN adds outputs fwd_valid (1), fwd_rd (5) and fwd_data (64) for the execute-stage bypass.
- With the macro: fwd_valid = full && reg_write && rd!=0 && !fault, independent of wb_stall. fwd_rd and fwd_data carry the final writeback value.
- Without the macro: the ports are absent, and the hazard unit stalls on the scoreboard until sb_clear.

Test Plan:
- Reset, then mem_valid with wb_sel=00, rd=5, alu=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, sb_clear=1, instret=1.
- LB with raw=0x80FF_0000_0000_0000 and alu[2:0]=7 → rf_wdata=0xFFFF_FFFF_FFFF_FF80. The same entry as LBU → 0x80.
- LW with alu[1:0]=2 → wb_fault=1, wb_fault_pc=mem_pc, rf_we=0, sb_clear=1, instret increments.
- wb_stall held 3 cycles with a second mem_valid pending → mem_ready=0 and rf_we=0 for 3 cycles. Both instructions then commit on consecutive cycles and instret increases by 2.
- mem_valid every cycle for 8 cycles with no stall → 8 writes on consecutive cycles with no bubbles. rd=0 entries produce rf_we=0 but still count.
- reset asserted while full → entry dropped, no rf_we, instret=0. wb_sel=10 with pc=0xFFFF_FFFF_FFFF_FFFC → rf_wdata=0.
